// File: rtl/matrix_operand_loader_if.sv
// Handshake bundle between the element stream, the operand loader and the matrix multiplier.
interface matrix_operand_loader_if #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned BUS_W = ELEM_W * DIM * DIM;

  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [BUS_W-1:0]  out_bus;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_b;
  logic              err_len;
  logic [CNT_W-1:0]  pair_count;

  // Environment side: feeds elements, consumes operands.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_bus, out_valid, out_is_b, err_len, pair_count
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_bus, out_valid, out_is_b, err_len, pair_count
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Packs 16-bit elements into two matrix words and releases them as a back-to-back A/B pair.
// Optional MATRIX_TRANSPOSE_B_EN: B arrives column-major and is stored row-major.
module matrix_operand_loader #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  matrix_operand_loader_if.slave bus
);
  localparam int unsigned NUM_ELEM = DIM * DIM;
  localparam int unsigned IDX_W    = $clog2(NUM_ELEM);
  localparam int unsigned BUS_W    = ELEM_W * NUM_ELEM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {FILL_A, FILL_B, SEND_A, SEND_B} state_t;

  state_t            state, stateNext;
  logic [IDX_W-1:0]  elemCnt, elemCntNext;
  logic [IDX_W-1:0]  idxB;
  logic [ELEM_W-1:0] bufA [NUM_ELEM];
  logic [ELEM_W-1:0] bufB [NUM_ELEM];
  logic [BUS_W-1:0]  packA, packB;

  logic wrA, wrB, errSet, pairInc, loadA, loadB;
  logic inReadyNext, outValidNext, outIsBNext;
  logic accept, deliver;

  logic              inReadyQ, outValidQ, outIsBQ, errLenQ;
  logic [CNT_W-1:0]  pairCountQ;
  logic [BUS_W-1:0]  outBusQ;

  assign accept  = bus.in_valid & inReadyQ;
  assign deliver = outValidQ & bus.out_ready;

`ifdef MATRIX_TRANSPOSE_B_EN
  // Column-major element k lands at row k%DIM, column k/DIM.
  assign idxB = IDX_W'((32'(elemCnt) % DIM) * DIM + 32'(elemCnt) / DIM);
`else
  assign idxB = elemCnt;
`endif

  // Flatten buffers into row-major bus words.
  always_comb begin
    packA = '0;
    packB = '0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      packA[k*ELEM_W +: ELEM_W] = bufA[k];
      packB[k*ELEM_W +: ELEM_W] = bufB[k];
    end
  end

  // Next-state and control decode.
  always_comb begin
    stateNext   = state;
    elemCntNext = elemCnt;
    wrA         = 1'b0;
    wrB         = 1'b0;
    errSet      = 1'b0;
    pairInc     = 1'b0;
    loadA       = 1'b0;
    loadB       = 1'b0;
    unique case (state)
      FILL_A, FILL_B: begin
        if (accept) begin
          if (bus.in_last && (elemCnt != LAST_IDX)) begin
            // Early terminator: drop the partial matrix, refill the same slot.
            errSet      = 1'b1;
            elemCntNext = '0;
          end else begin
            wrA = (state == FILL_A);
            wrB = (state == FILL_B);
            if (elemCnt == LAST_IDX) begin
              elemCntNext = '0;
              errSet      = ~bus.in_last;
              stateNext   = (state == FILL_A) ? FILL_B : SEND_A;
              loadA       = (state == FILL_B);
            end else begin
              elemCntNext = elemCnt + IDX_W'(1);
            end
          end
        end
      end
      SEND_A: begin
        if (deliver) begin
          stateNext = SEND_B;
          loadB     = 1'b1;
        end
      end
      SEND_B: begin
        if (deliver) begin
          stateNext = FILL_A;
          pairInc   = 1'b1;
        end
      end
      default: stateNext = FILL_A;
    endcase
    inReadyNext  = (stateNext == FILL_A) || (stateNext == FILL_B);
    outValidNext = (stateNext == SEND_A) || (stateNext == SEND_B);
    outIsBNext   = (stateNext == SEND_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL_A;
      elemCnt    <= '0;
      inReadyQ   <= 1'b0;
      outValidQ  <= 1'b0;
      outIsBQ    <= 1'b0;
      errLenQ    <= 1'b0;
      pairCountQ <= '0;
      outBusQ    <= '0;
      for (int unsigned i = 0; i < NUM_ELEM; i++) begin
        bufA[i] <= '0;
        bufB[i] <= '0;
      end
    end else begin
      state     <= stateNext;
      elemCnt   <= elemCntNext;
      inReadyQ  <= inReadyNext;
      outValidQ <= outValidNext;
      outIsBQ   <= outIsBNext;
      if (errSet)  errLenQ    <= 1'b1;
      if (pairInc) pairCountQ <= pairCountQ + CNT_W'(1);
      if (wrA)     bufA[elemCnt] <= bus.in_data;
      if (wrB)     bufB[idxB]    <= bus.in_data;
      if (loadA)      outBusQ <= packA;
      else if (loadB) outBusQ <= packB;
    end
  end

  assign bus.in_ready   = inReadyQ;
  assign bus.out_valid  = outValidQ;
  assign bus.out_is_b   = outIsBQ;
  assign bus.out_bus    = outBusQ;
  assign bus.err_len    = errLenQ;
  assign bus.pair_count = pairCountQ;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: queue-based operand model plus literal spot checks.
module tb_matrix_operand_loader;
`ifdef MATRIX_TRANSPOSE_B_EN
  localparam bit TRB = 1'b1;
`else
  localparam bit TRB = 1'b0;
`endif

  typedef struct packed {
    logic [255:0] data;
    logic         isB;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_operand_loader_if #(.ELEM_W(16), .DIM(4), .CNT_W(16)) bus ();
  matrix_operand_loader #(.ELEM_W(16), .DIM(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int nTests = 0;
  int nFail  = 0;
  int cycle  = 0;
  int popA   = 0;
  int popB   = 0;
  bit randReady = 1'b0;

  logic [15:0]  cur[$];
  logic [255:0] matA;
  bit           haveA = 1'b0;
  bit           mErr  = 1'b0;
  logic [15:0]  mPairs = 16'd0;
  beat_t        expQ[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [255:0] packMat(input logic [15:0] e[16], input bit colMajor);
    logic [255:0] r = '0;
    for (int k = 0; k < 16; k++) begin
      int idx = colMajor ? ((k % 4) * 4 + k / 4) : k;
      r[idx*16 +: 16] = e[k];
    end
    return r;
  endfunction

  // Model: a matrix counts once 16 elements arrive; an early in_last discards it.
  task automatic modelElem(input logic [15:0] d, input bit last);
    logic [15:0] m[16];
    cur.push_back(d);
    if (cur.size() == 16) begin
      if (!last) mErr = 1'b1;
      for (int k = 0; k < 16; k++) m[k] = cur[k];
      if (!haveA) begin
        matA  = packMat(m, 1'b0);
        haveA = 1'b1;
      end else begin
        expQ.push_back('{data: matA, isB: 1'b0});
        expQ.push_back('{data: packMat(m, TRB), isB: 1'b1});
        haveA = 1'b0;
      end
      cur.delete();
    end else if (last) begin
      mErr = 1'b1;
      cur.delete();
    end
  endtask

  task automatic modelReset();
    cur.delete();
    expQ.delete();
    haveA  = 1'b0;
    mErr   = 1'b0;
    mPairs = 16'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendElem(input logic [15:0] d, input bit last);
    bit ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'($urandom);
    if (ok) modelElem(d, last);
    else begin
      nTests++;
      nFail++;
      $display("FAIL send_timeout: element %0h not accepted within 300 cycles", d);
    end
  endtask

  task automatic sendMat(input logic [15:0] e[16], input int gapMax);
    for (int k = 0; k < 16; k++) begin
      if (gapMax > 0) idle($urandom_range(0, gapMax));
      sendElem(e[k], k == 15);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) idle(1);
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", expQ.size());
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("err_len", 256'(bus.err_len), 256'(mErr));
      check("pair_count", 256'(bus.pair_count), 256'(mPairs));
      check("out_valid", 256'(bus.out_valid), 256'(expQ.size() != 0));
      if (bus.out_valid && expQ.size() != 0) begin
        check("in_ready_while_valid", 256'(bus.in_ready), 256'(0));
        check("out_bus", bus.out_bus, expQ[0].data);
        check("out_is_b", 256'(bus.out_is_b), 256'(expQ[0].isB));
        if (bus.out_ready) begin
          if (expQ[0].isB) begin
            mPairs = mPairs + 16'd1;
            popB   = cycle;
          end else popA = cycle;
          void'(expQ.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a[16];
    logic [15:0] b[16];
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("rst_out_bus", bus.out_bus, 256'(0));
    check("rst_out_is_b", 256'(bus.out_is_b), 256'(0));
    check("rst_err_len", 256'(bus.err_len), 256'(0));
    check("rst_pair_count", 256'(bus.pair_count), 256'(0));
    #2 rst = 1'b0;
    check("in_ready_before_edge", 256'(bus.in_ready), 256'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 256'(bus.in_ready), 256'(1));

    // Test 1: A = 1..16, B = identity, latency and literal beats
    for (int k = 0; k < 16; k++) begin
      a[k] = 16'(k + 1);
      b[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
    end
    sendMat(a, 0);
    for (int k = 0; k < 15; k++) sendElem(b[k], 1'b0);
    check("t1_valid_before_32nd", 256'(bus.out_valid), 256'(0));
    sendElem(b[15], 1'b1);
    check("t1_valid_after_32nd", 256'(bus.out_valid), 256'(1));
    check("t1_a_is_b", 256'(bus.out_is_b), 256'(0));
    check("t1_a_lo", 256'(bus.out_bus[15:0]), 256'(1));
    check("t1_a_hi", 256'(bus.out_bus[255:240]), 256'(16));
    idle(1);
    check("t1_b_is_b", 256'(bus.out_is_b), 256'(1));
    check("t1_b_e0", 256'(bus.out_bus[15:0]), 256'(1));
    check("t1_b_e1", 256'(bus.out_bus[31:16]), 256'(0));
    idle(1);
    check("t1_pair_count", 256'(bus.pair_count), 256'(1));

    // Test 2: back-pressure holds A, then A/B on consecutive cycles
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a[k] = 16'(k * 3 + 7);
      b[k] = 16'(k) ^ 16'hA5A5;
    end
    sendMat(a, 0);
    sendMat(b, 0);
    idle(5);
    check("t2_stall_valid", 256'(bus.out_valid), 256'(1));
    check("t2_stall_is_b", 256'(bus.out_is_b), 256'(0));
    check("t2_stall_in_ready", 256'(bus.in_ready), 256'(0));
    bus.out_ready = 1'b1;
    drain();
    check("t2_back_to_back", 256'(popB - popA), 256'(1));

    // Test 3: early in_last on 8th element, then a clean pair 100..131
    for (int k = 0; k < 8; k++) sendElem(16'(k + 1), k == 7);
    idle(2);
    check("t3_err_len", 256'(bus.err_len), 256'(1));
    check("t3_no_output", 256'(bus.out_valid), 256'(0));
    for (int k = 0; k < 16; k++) begin
      a[k] = 16'(100 + k);
      b[k] = 16'(116 + k);
    end
    sendMat(a, 0);
    sendMat(b, 0);
    check("t3_a_lo", 256'(bus.out_bus[15:0]), 256'(100));
    idle(1);
    check("t3_b_lo", 256'(bus.out_bus[15:0]), 256'(116));
    drain();

    // Test 4: async reset after 20 elements discards everything
    for (int k = 0; k < 20; k++) sendElem(16'(500 + k), k == 15);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid", 256'(bus.out_valid), 256'(0));
    check("t4_rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("t4_rst_err", 256'(bus.err_len), 256'(0));
    check("t4_rst_pairs", 256'(bus.pair_count), 256'(0));
    check("t4_rst_bus", bus.out_bus, 256'(0));
    modelReset();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      a[k] = 16'(200 + k);
      b[k] = 16'(216 + k);
    end
    sendMat(a, 0);
    sendMat(b, 0);
    drain();
    check("t4_pair_count", 256'(bus.pair_count), 256'(1));

    // Test 5: B = 0..15, storage order depends on transpose option
    for (int k = 0; k < 16; k++) begin
      a[k] = 16'(k);
      b[k] = 16'(k);
    end
    sendMat(a, 0);
    sendMat(b, 0);
    idle(1);
    check("t5_b_is_b", 256'(bus.out_is_b), 256'(1));
`ifdef MATRIX_TRANSPOSE_B_EN
    check("t5_b_e1", 256'(bus.out_bus[31:16]), 256'(4));
    check("t5_b_e4", 256'(bus.out_bus[79:64]), 256'(1));
`else
    check("t5_b_e1", 256'(bus.out_bus[31:16]), 256'(1));
`endif
    drain();

    // Test 6: random gaps and random back-pressure over 20 pairs
    randReady = 1'b1;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 16; k++) begin
        a[k] = 16'($urandom);
        b[k] = 16'($urandom);
      end
      sendMat(a, 3);
      sendMat(b, 3);
    end
    randReady = 1'b0;
    idle(2);
    bus.out_ready = 1'b1;
    drain();
    idle(1);
    check("t6_err_len", 256'(bus.err_len), 256'(0));
    check("t6_pair_count", 256'(bus.pair_count), 256'(22));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
